// File: rtl/zx_pkg.sv
// zx_pkg: shared state encoding and timing defaults for the memory arbiter
package zx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CPU, S_LD, S_REC} state_t;
  localparam int ACC_DEF = 3;
  localparam int REC_DEF = 1;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the external RAM port between the Z80 and a host loader, CPU first
module ram_arbiter
  import zx_pkg::*;
#(
  parameter int AW  = 19,
  parameter int ACC = ACC_DEF,
  parameter int REC = REC_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpuRd,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  input  logic          ldReq,
  input  logic          ldWr,
  input  logic [AW-1:0] ldA,
  input  logic [7:0]    ldD,
  output logic [7:0]    ldQ,
  output logic          ldAck,
  output logic [AW-1:0] ramA,
  output logic [7:0]    ramD,
  output logic          ramOe,
  output logic          ramWe,
  input  logic [7:0]    ramQ,
  output logic          busy
);
  localparam int CW = $clog2((ACC > REC ? ACC : REC) + 1);
  localparam logic [CW-1:0] ACC_C = CW'(ACC);
  localparam logic [CW-1:0] REC_C = CW'(REC);
  state_t state;
  logic [CW-1:0] cnt;
  logic wr, cpu_done, cpu_pend, last;
  assign cpu_pend = (cpuRd | cpuWr) & ~cpu_done;
  assign last = cnt == ACC_C;
  assign busy = state != S_IDLE;
  // one RAM access per CPU bus cycle: re-arm only once both strobes drop
  always_ff @(posedge clock or negedge reset)
    if (!reset) cpu_done <= 1'b0;
    else if (state == S_CPU && last) cpu_done <= 1'b1;
    else if (!cpuRd && !cpuWr) cpu_done <= 1'b0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr    <= 1'b0;
      ramA  <= '0;
      ramD  <= '0;
      ramOe <= 1'b0;
      ramWe <= 1'b0;
      cpuQ  <= '0;
      ldQ   <= '0;
      ldAck <= 1'b0;
    end else begin
      ldAck <= 1'b0;
      case (state)
        S_IDLE:
          if (cpu_pend) begin
            state <= S_CPU;
            cnt   <= CW'(1);
            wr    <= cpuWr;
            ramA  <= cpuA;
            ramD  <= cpuD;
            ramOe <= !cpuWr;
            ramWe <= cpuWr;
          end else if (ldReq) begin
            state <= S_LD;
            cnt   <= CW'(1);
            wr    <= ldWr;
            ramA  <= ldA;
            ramD  <= ldD;
            ramOe <= !ldWr;
            ramWe <= ldWr;
          end
        S_CPU, S_LD:
          if (last) begin
            state <= REC > 0 ? S_REC : S_IDLE;
            cnt   <= CW'(1);
            ramOe <= 1'b0;
            ramWe <= 1'b0;
            ldAck <= state == S_LD;
            if (!wr && state == S_CPU) cpuQ <= ramQ;
            if (!wr && state == S_LD) ldQ <= ramQ;
          end else begin
            cnt   <= cnt + CW'(1);
            // write strobe ends one cycle early so address/data hold past it
            ramWe <= wr && (cnt + CW'(1) < ACC_C);
          end
        default:
          if (cnt >= REC_C) state <= S_IDLE;
          else cnt <= cnt + CW'(1);
      endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks with a scoreboard of expected RAM accesses
module tb_ram_arbiter;
  localparam int ACC = 3;
  localparam int REC = 1;
  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;
  logic clock = 1'b0, reset = 1'b0;
  logic cpuRd = 1'b0, cpuWr = 1'b0, ldReq = 1'b0, ldWr = 1'b0;
  logic [18:0] cpuA = '0, ldA = '0, ramA;
  logic [7:0] cpuD = '0, ldD = '0, cpuQ, ldQ, ramD, ramQ;
  logic ldAck, ramOe, ramWe, busy;
  logic [7:0] mem [0:524287];
  exp_t exp_q[$];
  exp_t cur;
  int checks = 0, errors = 0, n_acc = 0, n_ack = 0, cyc = 0, run = 0;
  int st_prev = 0, st_last = 0, a0 = 0, k0 = 0;
  logic act, prev_act = 1'b0, prev_ack = 1'b0;

  ram_arbiter dut (
    .clock(clock), .reset(reset),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
    .ldReq(ldReq), .ldWr(ldWr), .ldA(ldA), .ldD(ldD), .ldQ(ldQ), .ldAck(ldAck),
    .ramA(ramA), .ramD(ramD), .ramOe(ramOe), .ramWe(ramWe), .ramQ(ramQ), .busy(busy)
  );

  always #5 clock = ~clock;
  assign ramQ = mem[ramA];
  always @(posedge clock) begin
    cyc++;
    if (ramWe) mem[ramA] = ramD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_ack(input int target, input int budget);
    for (int i = 0; i < budget && n_ack < target; i++) step(1);
    chk("ack_timeout", n_ack >= target, 1);
  endtask

  task automatic push(input logic wr, input logic [18:0] addr, input logic [7:0] data);
    exp_t e;
    e.wr = wr;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // access monitor: each new RAM strobe run is matched against the scoreboard
  always @(negedge clock) begin
    act = ramOe | ramWe;
    if (act && !prev_act) begin
      n_acc++;
      st_prev = st_last;
      st_last = cyc;
      chk("unexpected_access", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        chk("start_addr", 32'(ramA), 32'(cur.addr));
        chk("start_we", ramWe, cur.wr);
        chk("start_oe", ramOe, !cur.wr);
        if (cur.wr) chk("start_data", ramD, cur.data);
      end
      run = 1;
    end else if (act) begin
      run++;
      chk("hold_addr", 32'(ramA), 32'(cur.addr));
      if (cur.wr) chk("hold_data", ramD, cur.data);
    end
    if (!act && prev_act && reset) chk("strobe_len", run, cur.wr ? ACC - 1 : ACC);
    if (ldAck) begin
      n_ack++;
      chk("ack_width", prev_ack, 0);
    end
    prev_act = act;
    prev_ack = ldAck;
  end

  initial begin
    mem[19'h04000] = 8'h5A;
    mem[19'h01234] = 8'h3C;
    mem[19'h00400] = 8'h11;
    mem[19'h00401] = 8'h22;
    #3;
    chk("rst_ramA", 32'(ramA), 0);
    chk("rst_ramD", ramD, 0);
    chk("rst_ramOe", ramOe, 0);
    chk("rst_ramWe", ramWe, 0);
    chk("rst_cpuQ", cpuQ, 0);
    chk("rst_ldQ", ldQ, 0);
    chk("rst_ldAck", ldAck, 0);
    chk("rst_busy", busy, 0);
    step(2);
    reset = 1'b1;
    step(2);
    // CPU read held long: exactly one access
    cpuA = 19'h04000;
    cpuRd = 1'b1;
    push(1'b0, 19'h04000, 8'h00);
    a0 = n_acc;
    step(8);
    chk("t1_one_access", n_acc - a0, 1);
    chk("t1_cpuQ", cpuQ, 8'h5A);
    cpuRd = 1'b0;
    step(3);
    // loader write held: back-to-back accesses
    ldA = 19'h7FFFF;
    ldD = 8'hC3;
    ldWr = 1'b1;
    ldReq = 1'b1;
    push(1'b1, 19'h7FFFF, 8'hC3);
    push(1'b1, 19'h7FFFF, 8'hC3);
    k0 = n_ack;
    wait_ack(k0 + 2, 40);
    ldReq = 1'b0;
    chk("t2_gap", st_last - st_prev, ACC + REC + 1);
    step(4);
    chk("t2_acks", n_ack - k0, 2);
    chk("t2_mem", mem[19'h7FFFF], 8'hC3);
    chk("t2_idle", busy, 0);
    // collision: CPU first, loader after recovery
    cpuA = 19'h01234;
    cpuRd = 1'b1;
    ldA = 19'h7FFFF;
    ldWr = 1'b0;
    ldReq = 1'b1;
    push(1'b0, 19'h01234, 8'h00);
    push(1'b0, 19'h7FFFF, 8'h00);
    k0 = n_ack;
    step(4);
    chk("t3_cpuQ", cpuQ, 8'h3C);
    chk("t3_ldQ_untouched", ldQ, 8'h00);
    wait_ack(k0 + 1, 20);
    ldReq = 1'b0;
    chk("t3_ldQ", ldQ, 8'hC3);
    chk("t3_gap", st_last - st_prev, ACC + REC + 1);
    cpuRd = 1'b0;
    step(3);
    // CPU write raised during loader cycle 1
    ldA = 19'h04000;
    ldWr = 1'b0;
    ldReq = 1'b1;
    push(1'b0, 19'h04000, 8'h00);
    step(1);
    cpuA = 19'h00200;
    cpuD = 8'h77;
    cpuWr = 1'b1;
    ldReq = 1'b0;
    push(1'b1, 19'h00200, 8'h77);
    step(9);
    chk("t4_latency", st_last - st_prev, ACC + REC + 1);
    chk("t4_ldQ", ldQ, 8'h5A);
    chk("t4_mem", mem[19'h00200], 8'h77);
    cpuWr = 1'b0;
    step(3);
    // reset during cycle 2 of a CPU write
    cpuA = 19'h00300;
    cpuD = 8'h99;
    cpuWr = 1'b1;
    push(1'b1, 19'h00300, 8'h99);
    push(1'b1, 19'h00300, 8'h99);
    k0 = n_ack;
    a0 = n_acc;
    step(2);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_we_drop", ramWe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ack", ldAck, 0);
    step(2);
    reset = 1'b1;
    step(8);
    chk("t5_accesses", n_acc - a0, 2);
    chk("t5_no_ack", n_ack - k0, 0);
    chk("t5_mem", mem[19'h00300], 8'h99);
    cpuWr = 1'b0;
    step(3);
    // back-to-back CPU reads with one low cycle between
    cpuA = 19'h00400;
    cpuRd = 1'b1;
    push(1'b0, 19'h00400, 8'h00);
    step(6);
    chk("t6_first", cpuQ, 8'h11);
    cpuRd = 1'b0;
    step(1);
    cpuA = 19'h00401;
    cpuRd = 1'b1;
    push(1'b0, 19'h00401, 8'h00);
    step(6);
    chk("t6_second", cpuQ, 8'h22);
    cpuRd = 1'b0;
    step(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single external RAM/ROM port (19-bit address, 8-bit data) between the Z80 and a host loader.
- The host loader writes ROM images and snapshots, and reads memory back for save states.
- The CPU always wins and its wait is bounded, so CPU timing derived from the 3.5 MHz enable is preserved.
- Sits between the machine top level and the board memory pins, replacing the direct memR1/memW1/memA1 wiring.

Parameters:
- AW, 19: address width.
- ACC, 3: RAM access length in clock cycles, minimum 2.
- REC, 1: idle recovery cycles after every access, minimum 0.

Ports:
- clock  in  1  system clock, 56 MHz
- reset  in  1  asynchronous, active-low
- cpuRd  in  1  CPU memory read request (level; mreq && rd)
- cpuWr  in  1  CPU memory write request (level)
- cpuA   in  AW  CPU address
- cpuD   in  8  CPU write data
- cpuQ   out 8  CPU read data (held)
- ldReq  in  1  loader request (level)
- ldWr   in  1  loader direction: 1 = write, 0 = read
- ldA    in  AW  loader address
- ldD    in  8  loader write data
- ldQ    out 8  loader read data (held)
- ldAck  out 1  one-cycle completion pulse
- ramA   out AW  RAM address
- ramD   out 8  RAM write data
- ramOe  out 1  RAM output enable, active high
- ramWe  out 1  RAM write enable, active high
- ramQ   in  8  RAM read data
- busy   out 1  high whenever not in IDLE

Behaviour:
- Reset (asynchronous, active-low) forces all outputs to 0 and state to IDLE, and clears the cpuDone flag.
- Reset mid-access aborts the access immediately: ramWe drops, no ldAck is issued, and no data register is updated.
- States:
  - IDLE: grant decision.
  - CPU: serving a CPU access; counter runs 1..ACC.
  - LD: serving a loader access; counter runs 1..ACC.
  - REC: recovery; counter runs 1..REC.
- IDLE grant, evaluated every cycle:
  - CPU request is pending when (cpuRd|cpuWr) and !cpuDone; it enters CPU next cycle.
  - Else if ldReq, enter LD next cycle.
  - Else stay in IDLE.
  - Simultaneous CPU and loader requests: CPU wins; the loader waits.
- On entering CPU or LD:
  - ramA, ramD and the direction are latched from the granted requester and held for all ACC cycles.
  - Requester inputs are ignored until the next grant.
- Read access:
  - ramOe is high for all ACC cycles.
  - ramQ is captured at the end of cycle ACC into cpuQ or ldQ; the other register is unchanged.
- Write access:
  - ramWe is high in cycles 1..ACC-1 and low in cycle ACC (address/data hold).
  - ramOe is low.
- Completion:
  - CPU access sets cpuDone.
  - LD access pulses ldAck for exactly one cycle, coincident with the first cycle after the access.
- After an access, go to REC if REC > 0, else straight to IDLE.
- cpuDone clears on the first cycle with cpuRd = cpuWr = 0, so one CPU bus cycle produces exactly one RAM access.
- A direction change without the request going low (rd to wr) is not a new request.
- Loader request may stay high after ldAck, giving back-to-back accesses; a new grant needs at least one IDLE cycle.
- Worst-case CPU latency, from request to start of access, is ACC+REC+1 cycles: 5 clocks at defaults. This is well inside one T-state (16 clocks).
- Loader fairness is not guaranteed against the CPU, but the loader is served in every CPU idle window. At least 10 idle clocks exist per T-state at defaults.
- Outside accesses, ramOe/ramWe are 0; ramA/ramD hold their last value.

Decomposition:
- Shared package zx_pkg: state encoding (IDLE, CPU, LD, REC), and ACC_DEF/REC_DEF constants.
- Single module; the counter and state machine are kept together.
- No sub-module is warranted; a request-edge/cpuDone tracker may be a local always block.

Test Plan:
1. CPU read: ramQ = 8'h5A, cpuRd held 8 cycles, cpuA = 19'h04000 -> ramOe high exactly 3 cycles with ramA = 19'h04000; cpuQ = 8'h5A; exactly one access while cpuRd stays high.
2. Loader write: ldReq = 1, ldWr = 1, ldA = 19'h7FFFF, ldD = 8'hC3 -> ramWe high 2 cycles; ramA and ramD stable for 3 cycles; one ldAck pulse; ldReq held high yields a second access after REC + IDLE.
3. Collision: cpuRd and ldReq asserted on the same cycle -> CPU is served first; LD starts after 1 REC + 1 IDLE cycle; ldQ is untouched by the CPU read.
4. Loader in progress: cpuWr raised during cycle 1 of an LD access -> CPU access starts exactly 4 cycles later (finish LD, REC, IDLE), i.e. latency ≤ 5.
5. Reset: reset driven low during cycle 2 of a CPU write -> ramWe = 0 immediately, busy = 0, no ldAck; after release, pending cpuWr is served once.
6. Back-to-back CPU: cpuRd pulses separated by 1 low cycle -> two accesses; cpuQ updates each time (8'h11 then 8'h22).
